// File: rtl/sign_mag_pkg.sv
// Shared definitions for the sign-magnitude arithmetic blocks: default
// width, FSM state encoding and operation selector.
package sign_mag_pkg;

  localparam int WIDTH = 8;
  localparam int MAG_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/sign_mag_subtractor_serial_full_adder.sv
// One-bit full-adder cell used by the bit-serial datapath. The carry flop
// lives in the parent so this cell stays purely combinational.
module serial_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Sum and carry of the three input bits
  always_comb begin
    o_sum  = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule

// File: rtl/sign_mag_subtractor.sv
// Bit-serial sign-magnitude subtractor, diff = a - b.
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high; an output transfer happens on a rising edge where
// out_valid and out_ready are both high. in_ready is high only in IDLE,
// out_valid only in DONE, and diff is stable for the whole DONE state.
module sign_mag_subtractor
  import sign_mag_pkg::*;
#(
  parameter int WIDTH = sign_mag_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic [1:0]       o_dbg_state
);

  localparam int MAG_BITS = WIDTH - 1;
  localparam int CNT_W    = (MAG_BITS > 1) ? $clog2(MAG_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAG_BITS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [MAG_BITS-1:0] r_x;
  logic [MAG_BITS-1:0] r_y;
  logic [MAG_BITS-1:0] r_acc;
  logic                r_carry;
  logic [CNT_W-1:0]    r_cnt;
  op_t                 r_op;
  logic                r_sign;
  logic [WIDTH:0]      r_diff;

  logic                w_sa;
  logic                w_sb_eff;
  logic [MAG_BITS-1:0] w_ma;
  logic [MAG_BITS-1:0] w_mb;
  op_t                 w_setup_op;
  logic                w_setup_sign;
  logic [MAG_BITS-1:0] w_setup_x;
  logic [MAG_BITS-1:0] w_setup_y;
  logic                w_accept;
  logic                w_last;
  logic                w_y_bit;
  logic                w_sum;
  logic                w_cout;
  logic [MAG_BITS-1:0] w_acc_next;
  logic [WIDTH-1:0]    w_mag;
  logic                w_sign_final;

  assign w_sa     = a[WIDTH-1];
  assign w_sb_eff = ~b[WIDTH-1];
  assign w_ma     = a[MAG_BITS-1:0];
  assign w_mb     = b[MAG_BITS-1:0];
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == CALC) && (r_cnt == LAST_CNT);

  // Operand setup: subtraction becomes addition of -b; for unlike signs the
  // larger magnitude goes to X so the serial X + ~Y + 1 never borrows out.
  always_comb begin
    w_setup_op   = OP_ADD;
    w_setup_sign = w_sa;
    w_setup_x    = w_ma;
    w_setup_y    = w_mb;
    if (w_sa != w_sb_eff) begin
      w_setup_op = OP_SUB;
      if (w_ma < w_mb) begin
        w_setup_sign = w_sb_eff;
        w_setup_x    = w_mb;
        w_setup_y    = w_ma;
      end
    end
  end

  assign w_y_bit = r_y[0] ^ (r_op == OP_SUB);

  serial_full_adder u_fa (
    .i_a    (r_x[0]),
    .i_b    (w_y_bit),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Result assembly for the final CALC edge: the adder carry is the extra
  // magnitude bit for ADD, a SUB carry is the discarded two's-complement
  // wrap; a zero magnitude always reports a positive sign.
  always_comb begin
    w_acc_next   = {w_sum, r_acc[MAG_BITS-1:1]};
    w_mag        = {((r_op == OP_ADD) ? w_cout : 1'b0), w_acc_next};
    w_sign_final = r_sign & (|w_mag);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = CALC;
      CALC:    if (r_cnt == LAST_CNT) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready    = (r_state == IDLE);
    out_valid   = (r_state == DONE);
    diff        = r_diff;
    o_dbg_state = r_state;
  end

  // Serial datapath: latch operands on accept, one bit per CALC edge (LSB
  // first), capture the packed result on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
      r_sign  <= 1'b0;
      r_diff  <= '0;
    end else if (w_accept) begin
      r_x     <= w_setup_x;
      r_y     <= w_setup_y;
      r_acc   <= '0;
      r_carry <= (w_setup_op == OP_SUB);
      r_cnt   <= '0;
      r_op    <= w_setup_op;
      r_sign  <= w_setup_sign;
    end else if (r_state == CALC) begin
      r_x     <= r_x >> 1;
      r_y     <= r_y >> 1;
      r_acc   <= w_acc_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff <= {w_sign_final, w_mag};
      end
    end
  end

endmodule
